// File: rtl/pll_reset_ctrl_if.sv
// Signal bundle between the PLL reset sequencer and its environment.
interface pll_reset_ctrl_if #(
    parameter int unsigned STAT_W = 8
);
    logic              pll_locked;
    logic              soft_reset_req;
    logic              pll_rst;
    logic              sys_reset;
    logic [STAT_W-1:0] lock_loss_cnt;
    logic [STAT_W-1:0] retry_cnt;

    // Sequencer side: consumes lock and soft request, drives resets and status.
    modport slave (
        input  pll_locked,
        input  soft_reset_req,
        output pll_rst,
        output sys_reset,
        output lock_loss_cnt,
        output retry_cnt
    );

    // Environment side: PLL lock source and reset consumers.
    modport master (
        output pll_locked,
        output soft_reset_req,
        input  pll_rst,
        input  sys_reset,
        input  lock_loss_cnt,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, holds sys_reset
// until lock has been continuously stable, and retries on lock timeout.
module pll_reset_ctrl #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAT_W         = 8
) (
    input  logic         clk,
    input  logic         reset,
    pll_reset_ctrl_if.slave bus
);

    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [1:0] {
        S_PLL_RESET = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        sync_q;
    logic              locked_s;
    logic [STAT_W-1:0] loss_q, loss_d;
    logic [STAT_W-1:0] retry_q, retry_d;
    logic              pll_rst_q;
    logic              sys_reset_q;

    // Two-flop synchronizer for the asynchronous PLL lock signal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    // Next state, cycle counter and saturating status counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == S_RUN) ? cnt_q : cnt_q + CNT_W'(1);
        loss_d  = loss_q;
        retry_d = retry_q;
        case (state_q)
            S_PLL_RESET: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = S_PLL_RESET;
                    if (retry_q != '1) begin
                        retry_d = retry_q + STAT_W'(1);
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    if (loss_q != '1) begin
                        loss_d = loss_q + STAT_W'(1);
                    end
                end else if (bus.soft_reset_req) begin
                    state_d = S_STABLE;
                end
            end
            default: begin
                state_d = S_PLL_RESET;
            end
        endcase
        // Every state change restarts the window, so no partial credit carries over.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_PLL_RESET;
            cnt_q       <= '0;
            loss_q      <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == S_PLL_RESET);
            sys_reset_q <= (state_d != S_RUN);
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_reset     = sys_reset_q;
    assign bus.lock_loss_cnt = loss_q;
    assign bus.retry_cnt     = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with short parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pll_reset_ctrl;

    localparam int unsigned STAT_W = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pll_reset_ctrl_if #(.STAT_W(STAT_W)) bus ();

    pll_reset_ctrl #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .STAT_W        (STAT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.pll_locked = 1'b0;
        bus.soft_reset_req = 1'b0;

        // Reset values
        edges(2);
        check("rst_pll_rst", 8'(bus.pll_rst), 8'd1);
        check("rst_sys_reset", 8'(bus.sys_reset), 8'd1);
        check("rst_loss", 8'(bus.lock_loss_cnt), 8'd0);
        check("rst_retry", 8'(bus.retry_cnt), 8'd0);

        // 1. Release; pll_rst high 4 cycles; lock rises 10 cycles later
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            edges(1);
            check("t1_pll_rst", 8'(bus.pll_rst), (k < 4) ? 8'd1 : 8'd0);
            check("t1_sys_hold", 8'(bus.sys_reset), 8'd1);
        end
        bus.pll_locked = 1'b1;
        edges(10);
        check("t1_sys_before", 8'(bus.sys_reset), 8'd1);
        edges(1);
        check("t1_sys_release", 8'(bus.sys_reset), 8'd0);
        check("t1_retry", 8'(bus.retry_cnt), 8'd0);

        // 3. Lock drop of 3 cycles in RUN
        bus.pll_locked = 1'b0;
        edges(2);
        check("t3_sys_edge1", 8'(bus.sys_reset), 8'd0);
        edges(1);
        check("t3_sys_edge2", 8'(bus.sys_reset), 8'd1);
        check("t3_loss", 8'(bus.lock_loss_cnt), 8'd1);
        bus.pll_locked = 1'b1;
        edges(10);
        check("t3_sys_before", 8'(bus.sys_reset), 8'd1);
        check("t3_pll_rst", 8'(bus.pll_rst), 8'd0);
        edges(1);
        check("t3_sys_release", 8'(bus.sys_reset), 8'd0);

        // 4. Glitch while STABLE at cnt=5 restarts the window
        bus.pll_locked = 1'b0;
        edges(3);
        check("t4_sys_lost", 8'(bus.sys_reset), 8'd1);
        check("t4_loss", 8'(bus.lock_loss_cnt), 8'd2);
        bus.pll_locked = 1'b1;
        edges(6);
        bus.pll_locked = 1'b0;
        edges(2);
        bus.pll_locked = 1'b1;
        edges(3);
        check("t4_no_early_run", 8'(bus.sys_reset), 8'd1);
        edges(7);
        check("t4_sys_before", 8'(bus.sys_reset), 8'd1);
        edges(1);
        check("t4_sys_release", 8'(bus.sys_reset), 8'd0);
        check("t4_loss_kept", 8'(bus.lock_loss_cnt), 8'd2);

        // 5a. Soft reset pulse in RUN
        bus.soft_reset_req = 1'b1;
        edges(1);
        bus.soft_reset_req = 1'b0;
        check("t5_sys_assert", 8'(bus.sys_reset), 8'd1);
        for (int k = 1; k <= 7; k++) begin
            edges(1);
            check("t5_sys_hold", 8'(bus.sys_reset), 8'd1);
            check("t5_pll_rst", 8'(bus.pll_rst), 8'd0);
        end
        edges(1);
        check("t5_sys_release", 8'(bus.sys_reset), 8'd0);
        check("t5_loss_kept", 8'(bus.lock_loss_cnt), 8'd2);

        // 5b. Soft request coincident with synchronized lock loss
        bus.pll_locked = 1'b0;
        edges(2);
        bus.soft_reset_req = 1'b1;
        edges(1);
        bus.soft_reset_req = 1'b0;
        check("t5b_sys", 8'(bus.sys_reset), 8'd1);
        check("t5b_loss", 8'(bus.lock_loss_cnt), 8'd3);
        check("t5b_pll_rst", 8'(bus.pll_rst), 8'd0);
        bus.pll_locked = 1'b1;
        edges(10);
        check("t5b_sys_before", 8'(bus.sys_reset), 8'd1);
        edges(1);
        check("t5b_sys_release", 8'(bus.sys_reset), 8'd0);

        // lock_loss_cnt saturates at 3
        bus.pll_locked = 1'b0;
        edges(3);
        check("sat_sys", 8'(bus.sys_reset), 8'd1);
        check("sat_loss", 8'(bus.lock_loss_cnt), 8'd3);
        bus.pll_locked = 1'b1;
        edges(11);
        check("sat_sys_release", 8'(bus.sys_reset), 8'd0);

        // 6b. Async reset mid-RUN, observed before the next clock edge
        edges(1);
        #2 reset = 1'b1;
        #1;
        check("t6r_pll_rst", 8'(bus.pll_rst), 8'd1);
        check("t6r_sys", 8'(bus.sys_reset), 8'd1);
        check("t6r_loss", 8'(bus.lock_loss_cnt), 8'd0);
        check("t6r_retry", 8'(bus.retry_cnt), 8'd0);

        // 2. Lock held low: retry every 36 cycles, retry_cnt saturates
        bus.pll_locked = 1'b0;
        edges(1);
        reset = 1'b0;
        for (int k = 1; k <= 154; k++) begin
            edges(1);
            check("t2_pll_rst", 8'(bus.pll_rst),
                  (k < 4) ? 8'd1 : ((((k - 4) % 36) >= 32) ? 8'd1 : 8'd0));
            check("t2_retry", 8'(bus.retry_cnt), ((k / 36) > 3) ? 8'd3 : 8'(k / 36));
            check("t2_sys", 8'(bus.sys_reset), 8'd1);
        end

        // Async reset clears a saturated retry counter
        #2 reset = 1'b1;
        #1;
        check("t6_retry_clr", 8'(bus.retry_cnt), 8'd0);
        check("t6_pll_rst", 8'(bus.pll_rst), 8'd1);

        // 6a. Async reset mid-STABLE, then a full sequence with lock already high
        edges(1);
        reset = 1'b0;
        bus.pll_locked = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            edges(1);
            check("t6s_pll_rst", 8'(bus.pll_rst), (k < 4) ? 8'd1 : 8'd0);
            check("t6s_sys", 8'(bus.sys_reset), 8'd1);
        end
        #2 reset = 1'b1;
        #1;
        check("t6s_async_pll_rst", 8'(bus.pll_rst), 8'd1);
        check("t6s_async_sys", 8'(bus.sys_reset), 8'd1);
        edges(1);
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            edges(1);
            check("t6_seq_pll_rst", 8'(bus.pll_rst), (k < 4) ? 8'd1 : 8'd0);
            check("t6_seq_sys", 8'(bus.sys_reset), (k < 13) ? 8'd1 : 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
